add64_slice_arbiter: RTL and testbench

- Shares one external 32-bit adder slice between two requesters.
- Each granted request is a full 64-bit add with carry-in, run over two slice passes: low word first, then high word with the registered carry.
- Round-robin arbitration between the requesters; valid/ready handshake on both request ports and on the result port.
- Sits between requesting datapath units and the single adder slice instance.

---
 rtl/add64_slice_arbiter.sv | 151 +++++++++++++++
 tb/tb_add64_slice_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add64_slice_arbiter.sv
// Two-requester round-robin front end for one shared 32-bit adder slice; each 64-bit add runs low word then high word.
// Optional macro ADD64_SLICE_ARB_SUB_EN adds per-request subtract (a - b) inputs req0_sub / req1_sub.
module add64_slice_arbiter #(
  parameter int W_SLICE = 32
) (
`ifdef ADD64_SLICE_ARB_SUB_EN
  input  logic                 req0_sub,
  input  logic                 req1_sub,
`endif
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [2*W_SLICE-1:0] req0_a,
  input  logic [2*W_SLICE-1:0] req0_b,
  input  logic                 req0_cin,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [2*W_SLICE-1:0] req1_a,
  input  logic [2*W_SLICE-1:0] req1_b,
  input  logic                 req1_cin,
  output logic [W_SLICE-1:0]   slice_a,
  output logic [W_SLICE-1:0]   slice_b,
  output logic                 slice_cin,
  input  logic [W_SLICE-1:0]   slice_sum,
  input  logic                 slice_cout,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*W_SLICE-1:0] res_sum,
  output logic                 res_cout,
  output logic                 res_id
);
  localparam int W = 2 * W_SLICE;

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_sum;
  logic               r_cin;
  logic               r_carry_mid;
  logic               r_cout;
  logic               r_id;
  logic               r_last_grant;
  logic               w_grant;
  logic               w_accept;
  logic               w_sub;
  logic [W_SLICE-1:0] w_b_lo;
  logic [W_SLICE-1:0] w_b_hi;

`ifdef ADD64_SLICE_ARB_SUB_EN
  logic r_sub;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sub <= 1'b0;
    end else if (w_accept) begin
      r_sub <= w_grant ? req1_sub : req0_sub;
    end
  end

  assign w_sub = r_sub;
`else
  assign w_sub = 1'b0;
`endif

  // Subtract is a + ~b + 1: invert b in both passes, force the low-pass carry-in.
  assign w_b_lo = r_b[W_SLICE-1:0] ^ {W_SLICE{w_sub}};
  assign w_b_hi = r_b[W-1:W_SLICE] ^ {W_SLICE{w_sub}};

  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    w_grant     = 1'b0;
    w_accept    = 1'b0;
    slice_a     = '0;
    slice_b     = '0;
    slice_cin   = 1'b0;
    case (r_state)
      IDLE: begin
        // On a tie, the requester that did not win last time goes first.
        if (req0_valid && (!req1_valid || r_last_grant)) begin
          req0_ready = 1'b1;
          w_accept   = 1'b1;
          w_grant    = 1'b0;
        end else if (req1_valid) begin
          req1_ready = 1'b1;
          w_accept   = 1'b1;
          w_grant    = 1'b1;
        end
        if (w_accept) w_state_nxt = LO;
      end
      LO: begin
        slice_a     = r_a[W_SLICE-1:0];
        slice_b     = w_b_lo;
        slice_cin   = r_cin | w_sub;
        w_state_nxt = HI;
      end
      HI: begin
        slice_a     = r_a[W-1:W_SLICE];
        slice_b     = w_b_hi;
        slice_cin   = r_carry_mid;
        w_state_nxt = RESP;
      end
      RESP: begin
        if (res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_cin        <= 1'b0;
      r_sum        <= '0;
      r_carry_mid  <= 1'b0;
      r_cout       <= 1'b0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a          <= w_grant ? req1_a   : req0_a;
        r_b          <= w_grant ? req1_b   : req0_b;
        r_cin        <= w_grant ? req1_cin : req0_cin;
        r_id         <= w_grant;
        r_last_grant <= w_grant;
      end
      if (r_state == LO) begin
        r_sum[W_SLICE-1:0] <= slice_sum;
        r_carry_mid        <= slice_cout;
      end
      if (r_state == HI) begin
        r_sum[W-1:W_SLICE] <= slice_sum;
        r_cout             <= slice_cout;
      end
    end
  end

  assign res_valid = (r_state == RESP);
  assign res_sum   = r_sum;
  assign res_cout  = r_cout;
  assign res_id    = r_id;

endmodule

// File: tb/tb_add64_slice_arbiter.sv
// Bench for add64_slice_arbiter: models the external adder slice and checks results against plain 65-bit arithmetic.
module tb_add64_slice_arbiter;
  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [63:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_cin, req1_cin;
  logic        req0_sub, req1_sub;
  logic [31:0] slice_a, slice_b, slice_sum;
  logic        slice_cin, slice_cout;
  logic        res_valid, res_ready;
  logic [63:0] res_sum;
  logic        res_cout, res_id;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  add64_slice_arbiter #(.W_SLICE(32)) dut (
`ifdef ADD64_SLICE_ARB_SUB_EN
    .req0_sub   (req0_sub),
    .req1_sub   (req1_sub),
`endif
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_cin  (slice_cin),
    .slice_sum  (slice_sum),
    .slice_cout (slice_cout),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_id     (res_id)
  );

  // The external adder slice: purely combinational.
  assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {32'd0, slice_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic cin, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + 65'd1;
    return {1'b0, a} + {1'b0, b} + {64'd0, cin};
  endfunction

  task automatic drive_req(input int id, input logic [63:0] a, input logic [63:0] b,
                           input logic cin, input logic sub);
    if (id == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; req0_sub = sub;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; req1_sub = sub;
    end
  endtask

  // Operands are scrambled after accept: the DUT must not rely on them being held.
  task automatic clear_reqs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
    req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
    req0_cin = 1'($urandom); req1_cin = 1'($urandom);
    req0_sub = 1'($urandom); req1_sub = 1'($urandom);
  endtask

  // Returns just after (#1) the accept edge, or with to=1 if never granted.
  task automatic wait_accept(input int id, output bit to);
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((id == 0) ? req0_ready : req1_ready) begin
        to = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the accept edge until res_valid is seen.
  task automatic wait_res(output int edges, output bit to);
    edges = 0;
    to    = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (res_valid) begin
        to = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  task automatic take_res();
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    clear_reqs();
    res_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
    n_vec++; if (res_sum !== 64'd0) begin n_err++; $display("FAIL reset_res_sum got %h want 0", res_sum); end
    n_vec++; if ({res_cout, res_id} !== 2'b00) begin n_err++; $display("FAIL reset_cout_id got %b want 00", {res_cout, res_id}); end
    n_vec++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b want 00", {req0_ready, req1_ready}); end
    n_vec++; if ({slice_a, slice_b, slice_cin} !== 65'd0) begin n_err++; $display("FAIL reset_slice got %h want 0", {slice_a, slice_b, slice_cin}); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Accept edge T, LO then HI, RESP visible after the second edge following T.
  task automatic test_single_add();
    bit to; int edges;
    drive_req(0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    wait_accept(0, to);
    clear_reqs();
    n_vec++; if (to) begin n_err++; $display("FAIL single_accept got timeout want grant"); end
    wait_res(edges, to);
    n_vec++; if (to || edges != 2) begin n_err++; $display("FAIL single_latency got %0d (to=%0b) want 2", edges, to); end
    n_vec++; if ({res_cout, res_sum} !== {1'b0, 64'h0000_0001_0000_0000}) begin n_err++; $display("FAIL single_sum got %b_%h want 0_0000000100000000", res_cout, res_sum); end
    n_vec++; if (res_id !== 1'b0) begin n_err++; $display("FAIL single_id got %b want 0", res_id); end
    take_res();
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL single_done got %b want 0", res_valid); end
  endtask

  task automatic test_full_wrap();
    bit to; int edges;
    drive_req(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
    wait_accept(1, to);
    clear_reqs();
    wait_res(edges, to);
    n_vec++; if (to) begin n_err++; $display("FAIL wrap_timeout got timeout want result"); end
    n_vec++; if ({res_cout, res_sum, res_id} !== {1'b1, 64'd0, 1'b1}) begin n_err++; $display("FAIL wrap got cout=%b sum=%h id=%b want 1 0 1", res_cout, res_sum, res_id); end
    take_res();
  endtask

  task automatic test_random();
    bit to; int edges; int id; int stall;
    logic [63:0] a, b; logic cin, sub; logic [64:0] exp;
    for (int n = 0; n < 40; n++) begin
      id  = int'($urandom_range(0, 1));
      a   = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      b   = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      cin = 1'($urandom);
`ifdef ADD64_SLICE_ARB_SUB_EN
      sub = 1'($urandom);
`else
      sub = 1'b0;
`endif
      exp = ref_add(a, b, cin, sub);
      drive_req(id, a, b, cin, sub);
      wait_accept(id, to);
      clear_reqs();
      wait_res(edges, to);
      stall = int'($urandom_range(0, 3));
      repeat (stall) begin @(posedge clk); #1; end
      n_vec++;
      if (to || res_valid !== 1'b1 || {res_cout, res_sum} !== exp || res_id !== 1'(id)) begin
        n_err++;
        $display("FAIL random[%0d] got v=%b %b_%h id=%b want 1 %b_%h id=%0d", n, res_valid, res_cout, res_sum, res_id, exp[64], exp[63:0], id);
      end
      take_res();
    end
  endtask

  task automatic test_contention();
    logic [63:0] a0, b0, a1, b1; logic [64:0] e0, e1;
    int ids[4]; logic [64:0] got[4]; int at[4]; int k;
    a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
    a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
    e0 = ref_add(a0, b0, 1'b1, 1'b0);
    e1 = ref_add(a1, b1, 1'b0, 1'b0);
    rst = 1'b1;
    drive_req(0, a0, b0, 1'b1, 1'b0);
    drive_req(1, a1, b1, 1'b0, 1'b0);
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 40 && k < 4; i++) begin
      @(negedge clk);
      if (res_valid) begin
        ids[k] = int'(res_id); got[k] = {res_cout, res_sum}; at[k] = cyc; k++;
      end
    end
    clear_reqs();
    n_vec++; if (k != 4) begin n_err++; $display("FAIL contention_count got %0d want 4", k); end
    for (int i = 0; i < k; i++) begin
      n_vec++;
      if (ids[i] != (i % 2) || got[i] !== ((i % 2) ? e1 : e0)) begin
        n_err++;
        $display("FAIL contention[%0d] got id=%0d %h want id=%0d %h", i, ids[i], got[i], i % 2, (i % 2) ? e1 : e0);
      end
      if (i > 0) begin
        n_vec++;
        if (at[i] - at[i-1] != 4) begin n_err++; $display("FAIL contention_interval[%0d] got %0d want 4", i, at[i] - at[i-1]); end
      end
    end
    repeat (6) @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit to; int edges; logic [64:0] exp, exp1; logic [63:0] a1, b1;
    res_ready = 1'b0;
    exp = ref_add(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
    a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
    exp1 = ref_add(a1, b1, 1'b0, 1'b0);
    drive_req(0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
    wait_accept(0, to);
    clear_reqs();
    drive_req(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    drive_req(1, a1, b1, 1'b0, 1'b0);
    wait_res(edges, to);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (res_valid !== 1'b1 || {res_cout, res_sum} !== exp || res_id !== 1'b0) begin
        n_err++; $display("FAIL bp_hold[%0d] got v=%b %b_%h id=%b want 1 %h id=0", i, res_valid, res_cout, res_sum, res_id, exp);
      end
      n_vec++;
      if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL bp_ready[%0d] got %b want 00", i, {req0_ready, req1_ready}); end
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL bp_release got %b want 0", res_valid); end
    // Requester 0 won last, so the pending tie goes to requester 1.
    n_vec++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL bp_next_grant got %b want 01", {req0_ready, req1_ready}); end
    @(posedge clk);
    #1;
    clear_reqs();
    wait_res(edges, to);
    n_vec++; if (to || res_id !== 1'b1 || {res_cout, res_sum} !== exp1) begin n_err++; $display("FAIL bp_second got id=%b %b_%h want 1 %h", res_id, res_cout, res_sum, exp1); end
    take_res();
  endtask

  task automatic test_reset_midop();
    bit to; int edges; logic [64:0] exp;
    drive_req(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    wait_accept(0, to);
    clear_reqs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_vec++; if (res_valid !== 1'b0 || {slice_a, slice_b, slice_cin} !== 65'd0) begin n_err++; $display("FAIL midrst_idle got v=%b slice=%h want 0 0", res_valid, {slice_a, slice_b, slice_cin}); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL midrst_no_result[%0d] got %b want 0", i, res_valid); end
    end
    @(posedge clk);
    #1;
    exp = ref_add(64'h8000_0000_0000_0001, 64'h8000_0000_FFFF_FFFF, 1'b1, 1'b0);
    drive_req(0, 64'h8000_0000_0000_0001, 64'h8000_0000_FFFF_FFFF, 1'b1, 1'b0);
    drive_req(1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    #1;
    n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL midrst_tie got %b want 10", {req0_ready, req1_ready}); end
    @(posedge clk);
    #1;
    clear_reqs();
    wait_res(edges, to);
    n_vec++; if (to || res_id !== 1'b0 || {res_cout, res_sum} !== exp) begin n_err++; $display("FAIL midrst_after got id=%b %b_%h want 0 %h", res_id, res_cout, res_sum, exp); end
    take_res();
  endtask

`ifdef ADD64_SLICE_ARB_SUB_EN
  task automatic test_sub();
    bit to; int edges;
    drive_req(0, 64'd5, 64'd7, 1'b0, 1'b1);
    wait_accept(0, to);
    clear_reqs();
    wait_res(edges, to);
    n_vec++; if (to || {res_cout, res_sum} !== {1'b0, 64'hFFFF_FFFF_FFFF_FFFE}) begin n_err++; $display("FAIL sub got %b_%h want 0_fffffffffffffffe", res_cout, res_sum); end
    take_res();
  endtask
`endif

  initial begin
    rst = 1'b1;
    res_ready = 1'b0;
    clear_reqs();
    test_reset();
    test_single_add();
    test_full_wrap();
    test_random();
    test_contention();
    test_backpressure();
    test_reset_midop();
`ifdef ADD64_SLICE_ARB_SUB_EN
    test_sub();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
